ser_addsub_seq: RTL and testbench

Parametrised bit-serial adder/subtractor with a start/busy/done handshake and a bit counter. Operands are loaded in parallel, processed LSB-first through one full-adder bit slice per clock, and the sum is streamed out serially while being assembled into a parallel result register. Subtraction uses two's complement: B is inverted at load and carry-in is 1. Intended as the reusable serial arithmetic unit for the datapath, replacing the fixed 16-bit, mode-pin-driven adder.

---
 rtl/ser_addsub_seq.sv | 122 ++++++++++++
 tb/tb_ser_addsub_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ser_addsub_seq.sv
// Bit-serial adder/subtractor: parallel load, LSB-first full-adder slice,
// serial sum stream plus assembled parallel result with carry/overflow flags.
module ser_addsub_seq #(
    parameter int WIDTH = 16,
    localparam int CNTW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             sum_bit,
    output logic             sum_valid,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [CNTW-1:0]  r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;

    logic             w_load;
    logic             w_shift;
    logic             w_last;
    logic             w_sum;
    logic             w_cnext;

    // One full-adder slice on the current LSBs
    assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cnext = (r_a[0] & r_b[0]) | (r_a[0] & r_carry)
                   | (r_b[0] & r_carry);
    assign w_last  = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Subtraction folds into addition: ~B with carry-in of 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_a     <= in1;
            r_b     <= sub ? ~in2 : in2;
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_result <= {w_sum, r_result[WIDTH-1:1]};
            r_carry  <= w_cnext;
            r_cnt    <= r_cnt + CNTW'(1);
            if (w_last) begin
                r_cout <= w_cnext;
                r_ovf  <= r_carry ^ w_cnext;
            end
        end
    end

    assign busy      = w_shift;
    assign sum_valid = w_shift;
    assign sum_bit   = w_shift & w_sum;
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ser_addsub_seq.sv
// Directed and random checks of ser_addsub_seq (WIDTH=16 and WIDTH=4)
// against a plain-arithmetic reference model.
module tb_ser_addsub_seq;

    logic        clk;
    logic        reset;
    logic        start16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, sbit16, sval16, done16, cout16, ovf16;
    logic [15:0] res16;
    logic        start4, sub4;
    logic [3:0]  a4, b4;
    logic        busy4, sbit4, sval4, done4, cout4, ovf4;
    logic [3:0]  res4;

    int checks = 0;
    int errors = 0;

    ser_addsub_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub16),
        .in1(a16), .in2(b16), .busy(busy16), .sum_bit(sbit16),
        .sum_valid(sval16), .done(done16), .result(res16),
        .cout(cout16), .ovf(ovf16)
    );

    ser_addsub_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4),
        .in1(a4), .in2(b4), .busy(busy4), .sum_bit(sbit4),
        .sum_valid(sval4), .done(done4), .result(res4),
        .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: r = A + (sub ? ~B : B) + sub modulo 2^w
    task automatic model(input int w, input logic [63:0] a, b,
                         input logic s, output logic [63:0] r,
                         output logic c, output logic v);
        logic [63:0] m, bb, full;
        m    = (64'd1 << w) - 64'd1;
        bb   = (s ? ~b : b) & m;
        full = (a & m) + bb + {63'd0, s};
        r    = full & m;
        c    = full[w];
        v    = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
    endtask

    task automatic op16(input logic [15:0] a, b, input logic s,
                        input bit glitch);
        logic [63:0] er;
        logic        ec, ev;
        logic [15:0] str;
        model(16, {48'd0, a}, {48'd0, b}, s, er, ec, ev);
        @(negedge clk);
        start16 = 1'b1; a16 = a; b16 = b; sub16 = s;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); sub16 = 1'($urandom);
        for (int i = 0; i < 16; i++) begin
            chk("busy16", {63'd0, busy16}, 64'd1);
            chk("sval16", {63'd0, sval16}, 64'd1);
            chk("nodone16", {63'd0, done16}, 64'd0);
            str[i]  = sbit16;
            start16 = (glitch && i == 4);
            if (start16) begin
                a16 = ~a; b16 = a; sub16 = ~s;
            end
            @(negedge clk);
        end
        start16 = 1'b0;
        chk("done16", {63'd0, done16}, 64'd1);
        chk("busy16_done", {63'd0, busy16}, 64'd0);
        chk("sbit16_done", {63'd0, sbit16}, 64'd0);
        chk("stream16", {48'd0, str}, er);
        chk("res16", {48'd0, res16}, er);
        chk("cout16", {63'd0, cout16}, {63'd0, ec});
        chk("ovf16", {63'd0, ovf16}, {63'd0, ev});
        @(negedge clk);
        chk("done16_once", {63'd0, done16}, 64'd0);
        chk("res16_hold", {48'd0, res16}, er);
    endtask

    task automatic op4(input logic [3:0] a, b, input logic s);
        logic [63:0] er;
        logic        ec, ev;
        logic [3:0]  str;
        model(4, {60'd0, a}, {60'd0, b}, s, er, ec, ev);
        @(negedge clk);
        start4 = 1'b1; a4 = a; b4 = b; sub4 = s;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy4", {63'd0, busy4}, 64'd1);
            str[i] = sbit4;
            @(negedge clk);
        end
        chk("done4", {63'd0, done4}, 64'd1);
        chk("stream4", {60'd0, str}, er);
        chk("res4", {60'd0, res4}, er);
        chk("cout4", {63'd0, cout4}, {63'd0, ec});
        chk("ovf4", {63'd0, ovf4}, {63'd0, ev});
        @(negedge clk);
        chk("done4_once", {63'd0, done4}, 64'd0);
    endtask

    initial begin
        int          k;
        int          ndone;
        int          first;
        int          last;
        logic [63:0] er;
        logic        ec, ev;

        reset = 1'b1;
        start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        #3 reset = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy16}, 64'd0);
        chk("rst_done", {63'd0, done16}, 64'd0);
        chk("rst_res", {48'd0, res16}, 64'd0);
        chk("rst_cout", {63'd0, cout16}, 64'd0);
        chk("rst_ovf", {63'd0, ovf16}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        op16(16'h1234, 16'h4321, 1'b0, 1'b0);
        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        op16(16'h0005, 16'h0007, 1'b1, 1'b0);
        op16(16'h8000, 16'h0001, 1'b1, 1'b0);
        op16(16'hA5C3, 16'h1F0E, 1'b0, 1'b1);

        // start held high: back-to-back operations every 18 cycles
        model(16, 64'h3C3C, 64'h0F0F, 1'b1, er, ec, ev);
        @(negedge clk);
        start16 = 1'b1; a16 = 16'h3C3C; b16 = 16'h0F0F; sub16 = 1'b1;
        ndone = 0; first = 0; last = 0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done16) begin
                if (ndone == 0) first = k;
                else chk("rep_spacing", 64'(k - last), 64'd18);
                last = k;
                ndone++;
                chk("rep_res", {48'd0, res16}, er);
            end
        end
        start16 = 1'b0;
        chk("rep_first", 64'(first), 64'd17);
        chk("rep_count", 64'(ndone), 64'd3);
        repeat (20) @(negedge clk);
        chk("rep_idle", {63'd0, busy16}, 64'd0);

        // asynchronous reset in the middle of a shift
        @(negedge clk);
        start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy16}, 64'd0);
        chk("arst_sval", {63'd0, sval16}, 64'd0);
        chk("arst_done", {63'd0, done16}, 64'd0);
        chk("arst_res", {48'd0, res16}, 64'd0);
        chk("arst_cout", {63'd0, cout16}, 64'd0);
        chk("arst_ovf", {63'd0, ovf16}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("arst_nodone", {63'd0, done16}, 64'd0);
        end
        op16(16'h0001, 16'h0001, 1'b0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
        end

        op4(4'hF, 4'hF, 1'b0);
        op4(4'h7, 4'h1, 1'b0);
        op4(4'h8, 4'h1, 1'b1);
        for (int n = 0; n < 8; n++) begin
            op4(4'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
